// File: rtl/adder32b_comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder32b_comparator_pkg
//  Description : Shared CPU ALU constants, comparator flag type and the
//                helper that turns an A-B result into compare flags.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder32b_comparator_pkg;

  // ALU datapath widths
  localparam int XLEN_DEFAULT = 32;
  localparam int SHAMT_W      = $clog2(XLEN_DEFAULT);

  // Comparator flags produced alongside the adder result
  typedef struct packed {
    logic eq;
    logic ls;
    logic lu;
  } cmp_flags_t;

  // Flags are derived from the subtraction result only:
  //  - equal when the difference is zero
  //  - unsigned less-than is the borrow, i.e. no carry out
  //  - signed less-than: with differing signs, A is smaller exactly when it
  //    is negative; with equal signs the difference cannot overflow, so its
  //    sign bit is the answer
  function automatic cmp_flags_t cmp_flags(input logic a_msb,
                                           input logic b_msb,
                                           input logic s_msb,
                                           input logic s_zero,
                                           input logic cout);
    cmp_flags_t f;
    f.eq = s_zero;
    f.lu = ~cout;
    f.ls = (a_msb != b_msb) ? a_msb : s_msb;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder32b_comparator_adder32b.sv
`default_nettype none
// ============================================================================
//  Module      : adder32b
//  Description : Combinational add/subtract: S = A + (B ^ {sub}) + sub,
//                with carry out of the most significant bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder32b
  import adder32b_comparator_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] s,
  output logic            cout
);

  logic [XLEN-1:0] w_b_eff;
  logic [XLEN:0]   w_full;

  // Invert B and inject the +1 carry-in for subtraction; one extra bit
  // captures the carry out of the MSB.
  assign w_b_eff = b ^ {XLEN{sub}};
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, sub};
  assign s       = w_full[XLEN-1:0];
  assign cout    = w_full[XLEN];

endmodule
`default_nettype wire

// File: rtl/adder32b_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : adder32b_comparator
//  Description : Registered add/subtract unit with equal, signed-less-than
//                and unsigned-less-than flags. One-cycle latency, accepts a
//                new operation every cycle, holds results when idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder32b_comparator
  import adder32b_comparator_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic            valid_out,
  output logic [XLEN-1:0] s,
  output logic            cout,
  output logic            eq,
  output logic            ls,
  output logic            lu
);

  logic [XLEN-1:0] w_sum;
  logic            w_cout;
  cmp_flags_t      w_flags;

  logic            r_valid;
  logic [XLEN-1:0] r_s;
  logic            r_cout;
  logic            r_eq;
  logic            r_ls;
  logic            r_lu;

  adder32b #(
    .XLEN (XLEN)
  ) u_adder (
    .a    (a),
    .b    (b),
    .sub  (sub),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Flags come from the adder result regardless of sub; they are only
  // meaningful as comparisons when subtracting.
  assign w_flags = cmp_flags(a[XLEN-1], b[XLEN-1], w_sum[XLEN-1],
                             (w_sum == '0), w_cout);

  // Output registers: valid tracks valid_in every edge, results load only
  // on valid operations and otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_eq    <= 1'b0;
      r_ls    <= 1'b0;
      r_lu    <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_s    <= w_sum;
        r_cout <= w_cout;
        r_eq   <= w_flags.eq;
        r_ls   <= w_flags.ls;
        r_lu   <= w_flags.lu;
      end
    end
  end

  assign valid_out = r_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign eq        = r_eq;
  assign ls        = r_ls;
  assign lu        = r_lu;

endmodule
`default_nettype wire

// File: tb/tb_adder32b_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder32b_comparator
//  Description : Self-checking bench for adder32b_comparator: vector table,
//                signed-byte sweep, hold and asynchronous reset sequences,
//                results checked through an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder32b_comparator;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        eq;
    logic        ls;
    logic        lu;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        valid_out;
  logic [31:0] s;
  logic        cout;
  logic        eq;
  logic        ls;
  logic        lu;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[10];

  adder32b_comparator #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .valid_out (valid_out),
    .s         (s),
    .cout      (cout),
    .eq        (eq),
    .ls        (ls),
    .lu        (lu)
  );

  always #5 clk = ~clk;

  // Golden reference: subtraction uses plain comparisons, addition uses
  // the documented flag derivation from the sum.
  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic msub);
    res_t        r;
    logic [32:0] wide;
    if (msub) begin
      r.s    = ma - mb;
      r.cout = (ma >= mb);
      r.eq   = (ma == mb);
      r.ls   = ($signed(ma) < $signed(mb));
      r.lu   = (ma < mb);
    end else begin
      wide   = {1'b0, ma} + {1'b0, mb};
      r.s    = wide[31:0];
      r.cout = wide[32];
      r.eq   = (r.s == 32'd0);
      r.lu   = ~r.cout;
      r.ls   = (ma[31] != mb[31]) ? ma[31] : r.s[31];
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                              input logic vsub, input logic [31:0] es,
                              input logic ec, input logic ee, input logic el,
                              input logic eu);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vsub;
    v.exp.s = es; v.exp.cout = ec; v.exp.eq = ee; v.exp.ls = el; v.exp.lu = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one operation on the falling edge; valid ones queue an expectation.
  task automatic drive_op(input logic [31:0] da, input logic [31:0] db,
                          input logic dsub, input logic dv, input res_t de);
    @(negedge clk);
    a        = da;
    b        = db;
    sub      = dsub;
    valid_in = dv;
    if (dv) sb_q.push_back(de);
  endtask

  // Scoreboard consumer: every valid result must match the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (!reset && valid_out) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_valid: got s=0x%08h with no pending operation", s);
      end else begin
        e = sb_q.pop_front();
        if ({s, cout, eq, ls, lu} !== e) begin
          n_fail++;
          $display("FAIL result: got s=%08h c=%b eq=%b ls=%b lu=%b expected s=%08h c=%b eq=%b ls=%b lu=%b",
                   s, cout, eq, ls, lu, e.s, e.cout, e.eq, e.ls, e.lu);
        end
      end
    end
  end

  initial begin
    logic [31:0] sa;
    logic [31:0] sb;
    res_t        none;
    none     = '0;
    reset    = 1'b1;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;

    vecs[0] = mk(32'd5,        32'd5,        1'b1, 32'h0000_0000, 1, 1, 0, 0);
    vecs[1] = mk(32'hFFFFFF80, 32'h0000007F, 1'b1, 32'hFFFF_FF01, 1, 0, 1, 0);
    vecs[2] = mk(32'd3,        32'hFFFFFFFE, 1'b1, 32'h0000_0005, 0, 0, 0, 1);
    vecs[3] = mk(32'h80000000, 32'd1,        1'b1, 32'h7FFF_FFFF, 1, 0, 1, 0);
    vecs[4] = mk(32'd1,        32'd2,        1'b1, 32'hFFFF_FFFF, 0, 0, 1, 1);
    vecs[5] = mk(32'h7FFFFFFF, 32'd1,        1'b0, 32'h8000_0000, 0, 0, 1, 1);
    vecs[6] = mk(32'd0,        32'd0,        1'b0, 32'h0000_0000, 0, 1, 0, 1);
    vecs[7] = mk(32'h80000000, 32'h80000000, 1'b0, 32'h0000_0000, 1, 1, 0, 0);
    vecs[8] = mk(32'h12345678, 32'h12345678, 1'b1, 32'h0000_0000, 1, 1, 0, 0);
    vecs[9] = mk(32'hFFFFFFFF, 32'd1,        1'b0, 32'h0000_0000, 1, 1, 1, 0);

    // Reset state
    #2;
    chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset_s", s, 32'd0);
    chk("reset_flags", {27'd0, cout, eq, ls, lu}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Vector table, back-to-back; last entry is the wrap-around add
    for (int i = 0; i < 10; i++)
      drive_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, vecs[i].exp);

    // Idle cycles with changed operands must leave results untouched
    drive_op(32'hDEADBEEF, 32'h00C0FFEE, 1'b1, 1'b0, none);
    drive_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, none);
    @(negedge clk);
    #1;
    chk("hold_valid_out", {31'd0, valid_out}, 32'd0);
    chk("hold_s", s, 32'd0);
    chk("hold_flags", {27'd0, cout, eq, ls, lu}, {27'd0, 1'b1, 1'b1, 1'b1, 1'b0});

    // Signed-byte sweep of subtraction flags
    for (int i = -128; i < 128; i++) begin
      for (int j = -128; j < 128; j++) begin
        sa = 32'(i);
        sb = 32'(j);
        drive_op(sa, sb, 1'b1, 1'b1, model(sa, sb, 1'b1));
      end
    end
    drive_op(32'd0, 32'd0, 1'b0, 1'b0, none);
    repeat (2) @(negedge clk);
    chk("sweep_drained", sb_q.size(), 32'd0);

    // Asynchronous reset between edges while operations stream in
    drive_op(32'd10, 32'd3, 1'b1, 1'b1, model(32'd10, 32'd3, 1'b1));
    drive_op(32'd7,  32'd9, 1'b1, 1'b1, model(32'd7, 32'd9, 1'b1));
    @(posedge clk);
    #3;
    reset = 1'b1;
    sb_q.delete();
    #1;
    chk("async_rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("async_rst_s", s, 32'd0);
    chk("async_rst_flags", {27'd0, cout, eq, ls, lu}, 32'd0);
    @(negedge clk);
    a = 32'd100; b = 32'd1; sub = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    chk("rst_held_valid_out", {31'd0, valid_out}, 32'd0);
    reset    = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_valid_out", {31'd0, valid_out}, 32'd0);
    chk("post_rst_idle_s", s, 32'd0);
    drive_op(32'd100, 32'd1, 1'b1, 1'b1, model(32'd100, 32'd1, 1'b1));
    drive_op(32'd0, 32'd0, 1'b0, 1'b0, none);
    #1;
    chk("post_rst_first_valid", {31'd0, valid_out}, 32'd1);
    repeat (2) @(negedge clk);
    chk("final_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder32b_comparator.md
ADDER32B_COMPARATOR -- requirements
Module: adder32b_comparator

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  1  operands valid this cycle.
REQ-005 SHALL have port a  input  XLEN  operand A.
REQ-006 SHALL have port b  input  XLEN  operand B.
REQ-007 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-008 SHALL have port valid_out  output  1  registered results valid.
REQ-009 SHALL have port s  output  XLEN  registered sum/difference.
REQ-010 SHALL have port cout  output  1  registered carry out of bit XLEN-1.
REQ-011 SHALL have port eq  output  1  registered A==B flag.
REQ-012 SHALL have port ls  output  1  registered signed A<B flag.
REQ-013 SHALL have port lu  output  1  registered unsigned A<B flag.

Function
REQ-014 SHALL compute S = A + (B XOR {XLEN{sub}}) + sub, modulo 2^XLEN; COUT = carry out of the MSB of that sum.
REQ-015 SHALL compute EQ = 1 iff S == 0.
REQ-016 SHALL compute LU = NOT COUT (borrow of A-B).
REQ-017 SHALL compute LS = A[XLEN-1] when A[XLEN-1] != B[XLEN-1], else S[XLEN-1].
REQ-018 SHALL derive EQ/LS/LU from S/COUT irrespective of sub; flags are only meaningful when sub=1, and with sub=1 SHALL equal A==B, signed A<B, unsigned A<B for all 2^64 operand pairs.
REQ-019 SHALL register S, COUT, EQ, LS, LU into s, cout, eq, ls, lu on each rising clk edge where valid_in=1; latency exactly one cycle.
REQ-020 SHALL hold s, cout, eq, ls, lu unchanged on edges where valid_in=0.
REQ-021 SHALL register valid_out <= valid_in on every rising edge (no backpressure; a new operation every cycle is accepted).
REQ-022 SHALL have no combinational path from inputs to outputs.
REQ-023 SHALL wrap silently on signed/unsigned overflow; no overflow output, no exception.

Reset
REQ-024 SHALL, while reset=1, asynchronously force valid_out, s, cout, eq, ls, lu to 0, independent of clk.
REQ-025 SHALL discard any operation captured in the cycle reset asserts; first valid result after deassertion appears one edge after the first valid_in=1 edge.

Structure
REQ-026 SHALL place XLEN default constant in the shared cpu ALU package alongside other ALU width constants.
REQ-027 SHALL instantiate one sub-module, adder32b (combinational A, B, SUB -> S, COUT), with comparator flag logic and output registers in the top.

Verification
REQ-028 SHALL verify a=5, b=5, sub=1, valid_in=1 -> next cycle s=0, cout=1, eq=1, ls=0, lu=0, valid_out=1.
REQ-029 SHALL verify a=0xFFFFFF80, b=0x0000007F, sub=1 -> s=0xFFFFFF01, cout=1, eq=0, ls=1, lu=0.
REQ-030 SHALL verify a=3, b=0xFFFFFFFE, sub=1 -> s=0x00000005, cout=0, eq=0, ls=0, lu=1.
REQ-031 SHALL verify a=0xFFFFFFFF, b=1, sub=0 -> s=0, cout=1; then valid_in=0 with new operands -> outputs hold.
REQ-032 SHALL verify exhaustive sweep, a and b each sign-extended from -128..127, sub=1 -> eq/ls/lu match golden ==, signed <, unsigned <, zero mismatches.
REQ-033 SHALL verify reset asserted mid-stream between clock edges -> all outputs 0 immediately, valid_out=0 until one edge after valid_in=1 following deassertion.
